clk_divider_nch: RTL and testbench
==================================

Name: clk_divider_nch

Overview:
- Multi-channel successor to the single-channel clock divider, intended for step/timing generation in the stepper datapath.
- Provides CHANNELS independent integer dividers on one clock.
- Each channel has its own enable, pulse or square output mode, and a divisor.
- The divisor is shadowed so it updates glitch-free at the counter wrap, with a per-channel forced reload for phase alignment.

Parameters:
SIZE, 16, counter and divisor width per channel
CHANNELS, 4, number of independent divider channels

Ports:
clk_in  input  1  system clock, all logic on posedge
rst_n_in  input  1  reset, asynchronous, active-low
en_in  input  CHANNELS  per-channel enable
mode_in  input  CHANNELS  per-channel mode: 0 = one-cycle pulse, 1 = square wave
max_in  input  CHANNELS*SIZE  flattened divisors M; channel i uses bits [i*SIZE +: SIZE]
load_in  input  CHANNELS  per-channel forced reload: counter to 0, shadow regs reloaded
clk_out  output  CHANNELS  divided output, registered
wrap_out  output  CHANNELS  one-cycle strobe at terminal count, registered, independent of mode

Behaviour:
- Reset (rst_n_in low, async):
  - all counters, shadow divisors and shadow modes = 0;
  - clk_out = 0, wrap_out = 0;
  - held until the first posedge after release.
- Per channel, state is: counter r_count (SIZE bits), shadow divisor act_max, shadow mode act_mode. Channels are fully independent.
- Shadow load. act_max <= max_in[i] and act_mode <= mode_in[i] when any of the following holds:
  - en_in[i] = 0; or
  - load_in[i] = 1; or
  - enabled and r_count == act_max-1 (wrap); or
  - enabled and act_max == 0.
  Otherwise the shadows hold, so changes to max_in or mode_in mid-period are ignored until the wrap.
- Counter, evaluated in this priority order each edge:
  1. en_in[i] = 0 -> r_count <= 0.
  2. load_in[i] = 1 -> r_count <= 0.
  3. act_max == 0 -> r_count <= 0.
  4. r_count == act_max-1 -> r_count <= 0.
  5. Otherwise r_count <= r_count + 1.
- Compare arithmetic: act_max-1 is computed in SIZE bits. Maximum divisor is 2^SIZE-1; the counter never exceeds act_max-1.
- Outputs, registered. The values below apply when enabled, act_max != 0, and load_in[i] = 0:
  - wrap_out <= (r_count == act_max-1).
  - Pulse mode (act_mode = 0): clk_out <= (r_count == act_max-1). This gives one high cycle per M cycles.
  - Square mode (act_mode = 1): clk_out <= (r_count >= (act_max >> 1)). High time is ceil(M/2) cycles, low time floor(M/2).
- Forced-low cases: clk_out <= 0 and wrap_out <= 0 when en_in[i] = 0, load_in[i] = 1, or act_max == 0.
- M = 1: counter stays 0 and both modes give clk_out constant 1 while enabled; wrap_out is constant 1.
- M = 0 while enabled: channel is idle with outputs low. It resumes from count 0 on the edge after a nonzero max_in is loaded.
- Latency (enabled, shadow M loaded):
  - the first enabled edge samples r_count = 0;
  - in pulse mode, clk_out is first high in the cycle after the M-th enabled edge, then every M cycles;
  - a 0->1 transition on en_in has no partial first period.
- Disable mid-period: next edge clears the counter and drives both outputs low. Re-enable restarts the phase from 0.
- Simultaneous load_in and wrap: load wins. Counter goes to 0, outputs go low that cycle, and the shadow is reloaded (same value as wrap would load).
- Asserting load_in on several channels in the same cycle phase-aligns them exactly when their divisors are equal.

Test Plan:
- Reset behaviour: assert rst_n_in low asynchronously mid-count -> clk_out and wrap_out drop to 0 immediately without a clock edge. After release, en=1 with M=4 in pulse mode gives the first clk_out high after the 4th edge.
- Pulse mode, M=5, en held high for 50 cycles -> exactly 10 single-cycle clk_out pulses spaced 5 apart. wrap_out is coincident with clk_out.
- Square mode, M=5 -> clk_out is low 2 cycles, high 3, periodic. With M=2 the output alternates 0/1; with M=1 it is constant 1.
- Divisor change mid-period: M=8 running, max_in changed to 3 at count 2 -> the current period completes at 8, then periods of 3 follow, with no short or runt pulse. The same check applies to mode_in changing mid-period.
- Edge cases: M=0 with en=1 keeps outputs low and counter 0; then setting max_in=4 makes the first pulse appear 4 cycles after the load edge. Deasserting en mid-period drives clk_out low the next cycle.
- Multi-channel alignment: ch0 M=6 and ch1 M=6 started at different times, then load_in=2'b11 pulsed for one cycle -> both clk_out streams are identical afterwards. Meanwhile ch2 (M=3, square) is unaffected by the other channels' events.

Source files
------------

// File: rtl/clk_divider_nch.sv
`default_nettype none
// ============================================================================
//  Module   : clk_divider_nch
//  Purpose  : CHANNELS independent integer clock dividers with shadowed
//             divisor/mode, pulse or square output and per-channel reload.
//  Revision : 1.0
// ============================================================================
module clk_divider_nch #(
   parameter int SIZE     = 16,
   parameter int CHANNELS = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [CHANNELS-1:0]      en_in,
   input  logic [CHANNELS-1:0]      mode_in,
   input  logic [CHANNELS*SIZE-1:0] max_in,
   input  logic [CHANNELS-1:0]      load_in,
   output logic [CHANNELS-1:0]      clk_out,
   output logic [CHANNELS-1:0]      wrap_out
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [SIZE-1:0] count_q, count_d;
      logic [SIZE-1:0] act_max_q, act_max_d;
      logic            act_mode_q, act_mode_d;
      logic            clk_q, clk_d;
      logic            wrap_q, wrap_d;
      logic [SIZE-1:0] term_w;
      logic            at_term_w;
      logic            idle_w;

      assign term_w    = act_max_q - 1'b1;
      assign at_term_w = (count_q == term_w);
      assign idle_w    = !en_in[g] || load_in[g] || (act_max_q == '0);

      always_comb begin
         count_d    = count_q + 1'b1;
         act_max_d  = act_max_q;
         act_mode_d = act_mode_q;
         clk_d      = 1'b0;
         wrap_d     = 1'b0;
         // Shadows only follow the inputs at a period boundary, so mid-period
         // edits to max_in/mode_in cannot produce a runt period.
         if (idle_w || at_term_w) begin
            count_d    = '0;
            act_max_d  = max_in[g*SIZE +: SIZE];
            act_mode_d = mode_in[g];
         end
         if (!idle_w) begin
            wrap_d = at_term_w;
            clk_d  = act_mode_q ? (count_q >= (act_max_q >> 1)) : at_term_w;
         end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            count_q    <= '0;
            act_max_q  <= '0;
            act_mode_q <= 1'b0;
            clk_q      <= 1'b0;
            wrap_q     <= 1'b0;
         end else begin
            count_q    <= count_d;
            act_max_q  <= act_max_d;
            act_mode_q <= act_mode_d;
            clk_q      <= clk_d;
            wrap_q     <= wrap_d;
         end
      end

      assign clk_out[g]  = clk_q;
      assign wrap_out[g] = wrap_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_nch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_divider_nch
//  Purpose  : Directed table-driven and sequence checks for clk_divider_nch.
//  Revision : 1.0
// ============================================================================
module tb_clk_divider_nch;

   localparam int SIZE     = 16;
   localparam int CHANNELS = 4;
   localparam logic [15:0] Z = 16'd0;
   localparam logic [3:0]  N = 4'b0000;

   logic                     clk_in = 1'b0;
   logic                     rst_n_in = 1'b1;
   logic [CHANNELS-1:0]      en_in = '0;
   logic [CHANNELS-1:0]      mode_in = '0;
   logic [CHANNELS*SIZE-1:0] max_in = '0;
   logic [CHANNELS-1:0]      load_in = '0;
   logic [CHANNELS-1:0]      clk_out;
   logic [CHANNELS-1:0]      wrap_out;

   clk_divider_nch #(.SIZE(SIZE), .CHANNELS(CHANNELS)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .en_in    (en_in),
      .mode_in  (mode_in),
      .max_in   (max_in),
      .load_in  (load_in),
      .clk_out  (clk_out),
      .wrap_out (wrap_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [3:0]  en;
      logic [3:0]  mode;
      logic [3:0]  load;
      logic [63:0] mx;
      logic [3:0]  eclk;
      logic [3:0]  ewrap;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   k2 = 0;
   int   bad2 = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // ch2 runs square M=3 continuously through the alignment sequence
   task automatic tick2();
      tick();
      if (clk_out[2] !== ((k2 % 3) != 0)) bad2++;
      k2++;
   endtask

   task automatic add(input logic [3:0] en, input logic [3:0] mode, input logic [3:0] load,
                      input logic [15:0] m0, input logic [15:0] m1,
                      input logic [15:0] m2, input logic [15:0] m3,
                      input logic [3:0] ec, input logic [3:0] ew);
      vec_t v;
      v.en    = en;
      v.mode  = mode;
      v.load  = load;
      v.mx    = {m3, m2, m1, m0};
      v.eclk  = ec;
      v.ewrap = ew;
      tbl.push_back(v);
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i < last; i++) begin
         en_in   = tbl[i].en;
         mode_in = tbl[i].mode;
         load_in = tbl[i].load;
         max_in  = tbl[i].mx;
         tick();
         check($sformatf("row%0d clk", i), 64'(clk_out), 64'(tbl[i].eclk));
         check($sformatf("row%0d wrap", i), 64'(wrap_out), 64'(tbl[i].ewrap));
      end
   endtask

   initial begin
      logic        b;
      logic        w;
      int          s1_end;
      int          pulses;
      int          bad;
      int          wbad;
      int          mism;
      logic [14:0] e0;
      logic [14:0] e1;

      // ---- pulse M=4 latency on ch0 ----
      add(N, N, N, 16'd4, Z, Z, Z, N, N);
      for (int i = 0; i < 8; i++) begin
         b = ((i % 4) == 3);
         add(4'b0001, N, N, 16'd4, Z, Z, Z, {3'b000, b}, {3'b000, b});
      end
      s1_end = tbl.size();
      // ---- square M=5 on ch1 ----
      add(N, 4'b0010, N, Z, 16'd5, Z, Z, N, N);
      for (int i = 0; i < 10; i++) begin
         b = ((i % 5) >= 2);
         w = ((i % 5) == 4);
         add(4'b0010, 4'b0010, N, Z, 16'd5, Z, Z, {2'b00, b, 1'b0}, {2'b00, w, 1'b0});
      end
      // ---- square M=2, square M=1, pulse M=1 on ch1 ----
      add(N, 4'b0010, N, Z, 16'd2, Z, Z, N, N);
      for (int i = 0; i < 4; i++) begin
         b = ((i % 2) == 1);
         add(4'b0010, 4'b0010, N, Z, 16'd2, Z, Z, {2'b00, b, 1'b0}, {2'b00, b, 1'b0});
      end
      add(N, 4'b0010, N, Z, 16'd1, Z, Z, N, N);
      for (int i = 0; i < 3; i++)
         add(4'b0010, 4'b0010, N, Z, 16'd1, Z, Z, 4'b0010, 4'b0010);
      add(N, N, N, Z, 16'd1, Z, Z, N, N);
      for (int i = 0; i < 2; i++)
         add(4'b0010, N, N, Z, 16'd1, Z, Z, 4'b0010, 4'b0010);
      // ---- ch2: M=0 idle, load 4, mode switch, disable, re-enable, load vs wrap ----
      add(N, N, N, Z, Z, Z, Z, N, N);
      for (int i = 0; i < 3; i++) add(4'b0100, N, N, Z, Z, Z, Z, N, N);
      for (int i = 0; i < 4; i++) add(4'b0100, N, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, 4'b0100);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, N);
      add(N, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, 4'b0100);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, N);
      add(4'b0100, 4'b0100, 4'b0100, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, N, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, N);
      add(4'b0100, 4'b0100, N, Z, Z, 16'd4, Z, 4'b0100, 4'b0100);

      // ---- reset ----
      #1 rst_n_in = 1'b0;
      #2;
      check("reset clk", 64'(clk_out), 64'd0);
      check("reset wrap", 64'(wrap_out), 64'd0);
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;

      run_rows(0, s1_end);

      // async reset while ch0 output is high
      #2 rst_n_in = 1'b0;
      #1;
      check("async rst clk", 64'(clk_out), 64'd0);
      check("async rst wrap", 64'(wrap_out), 64'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      run_rows(s1_end, tbl.size());

      // ---- pulse M=5 for 50 cycles on ch3 ----
      en_in = N; mode_in = N; load_in = N;
      max_in = {16'd5, Z, Z, Z};
      tick();
      en_in = 4'b1000;
      pulses = 0; bad = 0; wbad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (clk_out[3] !== ((i % 5) == 4)) bad++;
         if (wrap_out[3] !== clk_out[3]) wbad++;
         if (clk_out[3] === 1'b1) pulses++;
      end
      check("m5 pulse count", 64'(pulses), 64'd10);
      check("m5 pulse spacing", 64'(bad), 64'd0);
      check("m5 wrap coincident", 64'(wbad), 64'd0);

      // ---- mid-period divisor change (ch0) and mode change (ch1) ----
      en_in = N; mode_in = 4'b0010; load_in = N;
      max_in = {Z, Z, 16'd4, 16'd8};
      tick();
      en_in = 4'b0011;
      tick();
      tick();
      max_in = {Z, Z, 16'd4, 16'd3};
      mode_in = N;
      e0 = 15'b100100100100000;
      e1 = 15'b010001000100011;
      for (int i = 0; i < 15; i++) begin
         tick();
         check($sformatf("midchg t%0d", i), 64'(clk_out[1:0]), 64'({e1[i], e0[i]}));
      end

      // ---- alignment of ch0/ch1 with forced reload; ch2 untouched ----
      en_in = N; mode_in = 4'b0100; load_in = N;
      max_in = {Z, 16'd3, 16'd6, 16'd6};
      tick();
      en_in = 4'b0101;
      tick2();
      tick2();
      en_in = 4'b0111;
      repeat (3) tick2();
      load_in = 4'b0011;
      tick2();
      check("align load edge", 64'(clk_out[1:0]), 64'd0);
      load_in = N;
      mism = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick2();
         if (clk_out[0] !== clk_out[1]) mism++;
         if (clk_out[0] !== ((i % 6) == 5)) bad++;
      end
      check("align identical", 64'(mism), 64'd0);
      check("align pattern", 64'(bad), 64'd0);
      check("ch2 unaffected", 64'(bad2), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
